// File: rtl/ddr_rd_burst_ctrl.sv
// ddr_rd_burst_ctrl: reads a frame buffer from DDR as fixed-length read bursts
// and forwards every 256-bit beat into the downstream read FIFO. Bursts are
// only issued while the FIFO has at least 2*BURST_LEN words of headroom.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. axi_arvalid is held with a stable axi_araddr/axi_arlen
// until accepted. axi_rready is high for the whole RDATA state, so a burst
// completes at the rate the slave sends beats. fifo_wr_en has no ready.
//
// The FSM state is held in state_q, which checkers can bind to directly.
module ddr_rd_burst_ctrl #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 256,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_BEATS = 115200,
  parameter int FIFO_DEPTH  = 256,
  parameter int LEVEL_WIDTH = 9
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [LEVEL_WIDTH-1:0] fifo_wr_water_level,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic                  axi_rvalid,
  input  logic                  axi_rlast,
  output logic                  axi_rready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  rd_err
);

  localparam int NBURSTS = FRAME_BEATS / BURST_LEN;
  localparam int BL_W    = (NBURSTS < 2) ? 1 : $clog2(NBURSTS + 1);
  localparam logic [31:0]           LEVEL_LIMIT = 32'(FIFO_DEPTH - 2 * BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 32);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(FRAME_BASE);
  localparam logic [BL_W-1:0]       RELOAD      = BL_W'(NBURSTS);
  localparam logic [8:0]            LAST_BEAT   = 9'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, AREQ, RDATA} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [BL_W-1:0] bursts_left;
  logic [8:0]      beat_cnt;
  logic            pending;

  logic ar_fire;
  logic r_fire;
  logic level_ok;
  logic restart;
  logic go;

  assign ar_fire  = axi_arvalid & axi_arready;
  assign r_fire   = axi_rvalid & axi_rready;
  assign level_ok = 32'(fifo_wr_water_level) <= LEVEL_LIMIT;
  // A restart (new or pending frame_start) is applied only from IDLE so an
  // issued burst is never cut short.
  assign restart  = (state_q == IDLE) && (frame_start || pending);
  assign go       = enable && (bursts_left != '0) && !frame_start && !pending && level_ok;

  assign axi_arvalid = (state_q == AREQ);
  assign axi_rready  = (state_q == RDATA);
  assign axi_arlen   = 8'(BURST_LEN - 1);

  // FSM state register.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: issue, wait for address accept, collect beats until rlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = AREQ;
      AREQ:    if (ar_fire) state_d = RDATA;
      RDATA:   if (r_fire && axi_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame bookkeeping: address, burst count, beat count, status flags.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      axi_araddr  <= BASE_ADDR;
      bursts_left <= '0;
      beat_cnt    <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      rd_err      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (restart) begin
        axi_araddr  <= BASE_ADDR;
        bursts_left <= RELOAD;
        busy        <= 1'b1;
        pending     <= 1'b0;
      end else if (frame_start) begin
        pending <= 1'b1;
      end
      if (ar_fire) begin
        axi_araddr <= axi_araddr + BURST_BYTES;
        beat_cnt   <= '0;
      end
      if (r_fire) begin
        beat_cnt <= beat_cnt + 9'd1;
        if (axi_rlast != (beat_cnt == LAST_BEAT)) rd_err <= 1'b1;
        if (axi_rlast) begin
          bursts_left <= bursts_left - BL_W'(1);
          if (bursts_left == BL_W'(1)) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            axi_araddr <= BASE_ADDR;
          end
        end
      end
    end
  end

  // One register stage from the read channel into the FIFO.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= r_fire;
      if (r_fire) fifo_wr_data <= axi_rdata;
    end
  end

endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// tb_ddr_rd_burst_ctrl: directed bench for the DDR read burst master, small
// 32-beat frame at base 0x100 with 16-beat bursts.
module tb_ddr_rd_burst_ctrl;

  localparam int AW = 28;
  localparam int DW = 256;
  localparam int LW = 9;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          enable = 1'b0;
  logic          frame_start = 1'b0;
  logic [LW-1:0] fifo_wr_water_level = '0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready = 1'b0;
  logic [DW-1:0] axi_rdata = '0;
  logic          axi_rvalid = 1'b0;
  logic          axi_rlast = 1'b0;
  logic          axi_rready;
  logic          busy;
  logic          frame_done;
  logic          rd_err;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int burst_no = 0;
  logic [DW-1:0] exp_q[$];

  ddr_rd_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(16), .FRAME_BASE(32'h100),
    .FRAME_BEATS(32), .FIFO_DEPTH(256), .LEVEL_WIDTH(LW)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .frame_start(frame_start),
    .fifo_wr_water_level(fifo_wr_water_level), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rready(axi_rready),
    .busy(busy), .frame_done(frame_done), .rd_err(rd_err)
  );

  // Clock and reset.
  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int b, input int i);
    logic [DW-1:0] p;
    logic [31:0]   w;
    w = 32'hC0DE_0000 + 32'(b * 64 + i);
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = w + 32'(k << 24);
    return p;
  endfunction

  // Scoreboard: every FIFO write must match the next beat the slave sent.
  always @(negedge rd_clk) begin
    if (!rd_rst && fifo_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_write", 1, 0);
      else chk("sb_data", fifo_wr_data, exp_q.pop_front());
    end
    if (!rd_rst && frame_done) begin
      done_cnt++;
      chk("done_align_wr_en", fifo_wr_en, 1);
    end
  end

  // Driver: pulse frame_start for one cycle.
  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Driver: act as read slave for one burst. hold = cycles arready stays low,
  // nbeats beats sent, rlast on beat rlast_at, frame_start raised on beat fs_at.
  task automatic do_burst(input int hold, input int nbeats, input int rlast_at,
                          input int fs_at, output logic [AW-1:0] addr);
    bit seen = 0;
    addr = '0;
    for (int i = 0; i < 40; i++) begin
      if (axi_arvalid) begin seen = 1; break; end
      tick();
    end
    if (!seen) begin
      chk("arvalid_timeout", 0, 1);
      return;
    end
    addr = axi_araddr;
    chk("arlen", axi_arlen, 15);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_arvalid", axi_arvalid, 1);
      chk("hold_araddr", axi_araddr, addr);
    end
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    chk("ar_accepted_once", axi_arvalid, 0);
    for (int i = 0; i < nbeats; i++) begin
      chk("rready", axi_rready, 1);
      axi_rvalid  = 1'b1;
      axi_rdata   = pat(burst_no, i);
      axi_rlast   = (i == rlast_at);
      frame_start = (i == fs_at);
      exp_q.push_back(pat(burst_no, i));
      tick();
    end
    axi_rvalid  = 1'b0;
    axi_rlast   = 1'b0;
    frame_start = 1'b0;
    burst_no++;
    chk("turnaround_idle", axi_arvalid, 0);
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  initial begin
    logic [AW-1:0] a;
    int wr0;
    int d0;
    bit any;

    // Reset with random inputs: outputs must sit at reset values.
    for (int c = 0; c < 8; c++) begin
      enable              = 1'($urandom_range(0, 1));
      frame_start         = 1'($urandom_range(0, 1));
      fifo_wr_water_level = LW'($urandom_range(0, 511));
      axi_arready         = 1'($urandom_range(0, 1));
      axi_rvalid          = 1'($urandom_range(0, 1));
      axi_rlast           = 1'($urandom_range(0, 1));
      axi_rdata           = {8{$urandom()}};
      tick();
      chk("rst_arvalid", axi_arvalid, 0);
      chk("rst_rready", axi_rready, 0);
      chk("rst_araddr", axi_araddr, 28'h100);
      chk("rst_arlen", axi_arlen, 15);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_wr_data", fifo_wr_data, 0);
      chk("rst_flags", {busy, frame_done, rd_err}, 0);
    end
    enable = 1'b0; frame_start = 1'b0; fifo_wr_water_level = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = '0;
    tick();
    rd_rst = 1'b0;
    tick();
    chk("post_rst_idle", {axi_arvalid, busy, rd_err}, 0);

    // Small frame: two bursts, 32 writes in order, one frame_done.
    enable = 1'b1;
    wr0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    chk("start_busy", busy, 1);
    do_burst(0, 16, 15, -1, a);
    chk("burst0_addr", a, 28'h100);
    tick();
    chk("turnaround_areq", axi_arvalid, 1);
    do_burst(0, 16, 15, -1, a);
    chk("burst1_addr", a, 28'h300);
    drain();
    chk("frame_writes", wr_cnt - wr0, 32);
    chk("frame_done_cnt", done_cnt - d0, 1);
    chk("frame_end_busy", busy, 0);
    chk("frame_end_wrap", axi_araddr, 28'h100);
    any = 0;
    repeat (20) begin tick(); if (axi_arvalid) any = 1; end
    chk("no_arvalid_after_frame", any, 0);

    // Throttle: 225 blocks issue, 224 allows it on the next cycle.
    fifo_wr_water_level = 9'd225;
    pulse_start();
    any = 0;
    repeat (8) begin tick(); if (axi_arvalid) any = 1; end
    chk("throttle_225", any, 0);
    fifo_wr_water_level = 9'd224;
    tick();
    chk("throttle_224", axi_arvalid, 1);
    do_burst(0, 16, 15, -1, a);
    chk("throttle_addr", a, 28'h100);
    fifo_wr_water_level = '0;
    do_burst(0, 16, 15, -1, a);
    drain();

    // arready low for 5 cycles: request held stable, one burst accepted.
    wr0 = wr_cnt;
    pulse_start();
    do_burst(5, 16, 15, -1, a);
    chk("hold_burst_addr", a, 28'h100);
    do_burst(0, 16, 15, -1, a);
    chk("hold_next_addr", a, 28'h300);
    drain();
    chk("hold_writes", wr_cnt - wr0, 32);

    // frame_start on beat 7: burst completes, then restart at FRAME_BASE.
    wr0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    do_burst(0, 16, 15, 7, a);
    chk("fs_mid_addr0", a, 28'h100);
    drain();
    chk("fs_mid_writes", wr_cnt - wr0, 16);
    chk("fs_mid_no_done", done_cnt - d0, 0);
    do_burst(0, 16, 15, -1, a);
    chk("fs_restart_addr", a, 28'h100);
    do_burst(0, 16, 15, -1, a);
    chk("fs_reload_addr", a, 28'h300);
    drain();
    chk("fs_done_cnt", done_cnt - d0, 1);
    chk("fs_busy", busy, 0);

    // rlast on beat 10: burst ends early, rd_err set and sticky.
    chk("err_before", rd_err, 0);
    wr0 = wr_cnt;
    pulse_start();
    do_burst(0, 10, 9, -1, a);
    drain();
    chk("early_writes", wr_cnt - wr0, 10);
    chk("early_err", rd_err, 1);
    do_burst(0, 16, 15, -1, a);
    chk("early_next_addr", a, 28'h300);
    drain();
    chk("err_sticky", rd_err, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
